// File: rtl/lcd_timing_engine_if.sv
`timescale 1ns/1ps
// Pixel stream handshake between the LCD timing engine and its pixel source.
// The engine raises oREQ once per wanted pixel; the source answers with
// iDATA/iVALID a fixed number of cycles later.
interface lcd_timing_engine_if #(
   parameter int COLOR_W = 8
) ();
   logic                 oREQ;
   logic [3*COLOR_W-1:0] iDATA;
   logic                 iVALID;

   // Engine side: issues requests and consumes returned pixels
   modport master (
      output oREQ,
      input  iDATA,
      input  iVALID
   );

   // Source side: watches requests and returns pixels
   modport slave (
      input  oREQ,
      output iDATA,
      output iVALID
   );
endinterface

// File: rtl/lcd_timing_engine.sv
`timescale 1ns/1ps
// Parametrised LCD panel timing engine.
// Walks a raster of H_TOTAL x V_TOTAL clocks, produces active-low syncs,
// data enable and RGB. Colour source is picked once per frame: solid fill,
// eight colour bars, a latency-matched pixel stream, or blank. Every panel
// output is registered from the same counter state, so all of them lag the
// counters by exactly one clock.
module lcd_timing_engine #(
   parameter int H_TOTAL  = 1056,
   parameter int H_SYNC   = 30,
   parameter int H_BLANK  = 46,
   parameter int H_ACT    = 800,
   parameter int V_TOTAL  = 525,
   parameter int V_SYNC   = 13,
   parameter int V_BLANK  = 23,
   parameter int V_ACT    = 480,
   parameter int COLOR_W  = 8,
   parameter int READ_LAT = 2
) (
   input  logic                      iCLK,
   input  logic                      iRST_n,
   input  logic [1:0]                iMODE,
   input  logic [3*COLOR_W-1:0]      iFILL,
   input  logic                      iCLR_UNDERFLOW,
   lcd_timing_engine_if.master       stream,
   output logic                      oHD,
   output logic                      oVD,
   output logic                      oDE,
   output logic [COLOR_W-1:0]        oLCD_R,
   output logic [COLOR_W-1:0]        oLCD_G,
   output logic [COLOR_W-1:0]        oLCD_B,
   output logic                      oNewFrame,
   output logic                      oEndFrame,
   output logic                      oUNDERFLOW,
   output logic [15:0]               oFRAME_CNT
);

   // One extra bit of headroom so H_BLANK+H_ACT fits even when it equals
   // a power-of-two total
   localparam int XW    = $clog2(H_TOTAL + 1);
   localparam int YW    = $clog2(V_TOTAL + 1);
   localparam int BAR_W = H_ACT / 8;
   localparam int BW    = $clog2(BAR_W + 1);

   localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] X_SYNC = XW'(H_SYNC);
   localparam logic [XW-1:0] X_ACT0 = XW'(H_BLANK);
   localparam logic [XW-1:0] X_ACT1 = XW'(H_BLANK + H_ACT);
   localparam logic [XW-1:0] X_END  = XW'(H_BLANK + H_ACT - 1);
   localparam logic [XW-1:0] X_REQ0 = XW'(H_BLANK - READ_LAT);
   localparam logic [XW-1:0] X_REQ1 = XW'(H_BLANK + H_ACT - READ_LAT);

   localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] Y_SYNC = YW'(V_SYNC);
   localparam logic [YW-1:0] Y_ACT0 = YW'(V_BLANK);
   localparam logic [YW-1:0] Y_ACT1 = YW'(V_BLANK + V_ACT);
   localparam logic [YW-1:0] Y_END  = YW'(V_BLANK + V_ACT - 1);

   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

   typedef enum logic [1:0] {
      MODE_FILL   = 2'd0,
      MODE_BARS   = 2'd1,
      MODE_STREAM = 2'd2,
      MODE_BLANK  = 2'd3
   } mode_t;

   logic [XW-1:0]        x_cnt, x_nxt;
   logic [YW-1:0]        y_cnt, y_nxt;
   mode_t                mode_q;
   logic                 armed;
   logic [BW-1:0]        bar_pix;
   logic [2:0]           bar_idx;
   logic                 hs, vs, h_act, v_act, act;
   logic                 req_nxt;
   logic                 at_origin, at_last_pix;
   logic                 underflow_set;
   logic [3*COLOR_W-1:0] pix_rgb;

   // Next raster position: x wraps at the line end and carries into y
   always_comb begin
      x_nxt = x_cnt + 1'b1;
      y_nxt = y_cnt;
      if (x_cnt == X_LAST) begin
         x_nxt = '0;
         y_nxt = (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
      end
   end

   // Raster counters
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         x_cnt <= x_nxt;
         y_cnt <= y_nxt;
      end
   end

   // Counter-domain decodes feeding the registered output stage; the
   // request window is judged on the next position so oREQ lines up with it
   always_comb begin
      hs          = (x_cnt < X_SYNC);
      vs          = (y_cnt < Y_SYNC);
      h_act       = (x_cnt >= X_ACT0) && (x_cnt < X_ACT1);
      v_act       = (y_cnt >= Y_ACT0) && (y_cnt < Y_ACT1);
      act         = h_act && v_act;
      at_origin   = (x_cnt == '0) && (y_cnt == '0);
      at_last_pix = (x_cnt == X_END) && (y_cnt == Y_END);
      req_nxt     = (mode_q == MODE_STREAM) &&
                    (x_nxt >= X_REQ0) && (x_nxt < X_REQ1) &&
                    (y_nxt >= Y_ACT0) && (y_nxt < Y_ACT1);
   end

   // Mode is sampled only at the raster origin so a frame never mixes
   // sources; the frame that starts straight out of reset stays blank
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         mode_q <= MODE_BLANK;
         armed  <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (armed && at_origin) begin
            mode_q <= mode_t'(iMODE);
         end
      end
   end

   // Bar position tracked by a pixel-in-bar counter instead of dividing x;
   // it is primed on the cycle before the first active column
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         bar_pix <= '0;
         bar_idx <= '0;
      end else if (x_nxt == X_ACT0) begin
         bar_pix <= '0;
         bar_idx <= '0;
      end else if (h_act) begin
         if (bar_pix == BAR_LAST) begin
            bar_pix <= '0;
            bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_pix <= bar_pix + 1'b1;
         end
      end
   end

   // Pixel colour for the current position; a missing stream pixel turns
   // black and flags underflow. Bar order white..black falls out of the
   // inverted index bits: R=~idx[1], G=~idx[2], B=~idx[0]
   always_comb begin
      pix_rgb       = '0;
      underflow_set = 1'b0;
      if (act) begin
         case (mode_q)
            MODE_FILL: begin
               pix_rgb = iFILL;
            end
            MODE_BARS: begin
               pix_rgb = {{COLOR_W{~bar_idx[1]}},
                          {COLOR_W{~bar_idx[2]}},
                          {COLOR_W{~bar_idx[0]}}};
            end
            MODE_STREAM: begin
               if (stream.iVALID) begin
                  pix_rgb = stream.iDATA;
               end else begin
                  underflow_set = 1'b1;
               end
            end
            default: begin
               pix_rgb = '0;
            end
         endcase
      end
   end

   // Registered panel outputs, stream request and frame bookkeeping
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         oHD         <= 1'b1;
         oVD         <= 1'b1;
         oDE         <= 1'b0;
         oLCD_R      <= '0;
         oLCD_G      <= '0;
         oLCD_B      <= '0;
         stream.oREQ <= 1'b0;
         oNewFrame   <= 1'b0;
         oEndFrame   <= 1'b0;
         oFRAME_CNT  <= '0;
      end else begin
         oHD                      <= ~hs;
         oVD                      <= ~vs;
         oDE                      <= act;
         {oLCD_R, oLCD_G, oLCD_B} <= pix_rgb;
         stream.oREQ              <= req_nxt;
         oNewFrame                <= at_origin;
         oEndFrame                <= at_last_pix;
         if (at_last_pix) begin
            oFRAME_CNT <= oFRAME_CNT + 16'd1;
         end
      end
   end

   // Sticky underflow flag; a fresh underflow outranks a clear request
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         oUNDERFLOW <= 1'b0;
      end else if (underflow_set) begin
         oUNDERFLOW <= 1'b1;
      end else if (iCLR_UNDERFLOW) begin
         oUNDERFLOW <= 1'b0;
      end
   end

endmodule
